// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer and its environment
// (instruction memory, data memory, halt control and status observers).
interface instr_sequencer_if;
  // Inputs to the sequencer
  logic        SQHalt;
  logic        SQIMReady;
  logic [6:0]  SQIMOpcode;
  logic        SQDMReady;
  // Outputs from the sequencer
  logic        SQIMReq;
  logic        SQIRWr;
  logic        SQDMReq;
  logic        SQDMWrEn;
  logic        SQRUWrEn;
  logic        SQPCWr;
  logic        SQIllegal;
  logic [2:0]  SQState;
  logic [31:0] SQRetired;

  // Sequencer side
  modport master (
    input  SQHalt, SQIMReady, SQIMOpcode, SQDMReady,
    output SQIMReq, SQIRWr, SQDMReq, SQDMWrEn, SQRUWrEn, SQPCWr,
           SQIllegal, SQState, SQRetired
  );

  // Environment side
  modport slave (
    output SQHalt, SQIMReady, SQIMOpcode, SQDMReady,
    input  SQIMReq, SQIRWr, SQDMReq, SQDMWrEn, SQRUWrEn, SQPCWr,
           SQIllegal, SQState, SQRetired
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Strobes are decoded from the current state and the latched opcode; only the
// fetch load strobe and the MEM exit PC strobe also look at the ready inputs.
// An unknown opcode parks the machine in TRAP until reset.
module instr_sequencer (
  input  logic              SQClk,
  input  logic              SQRstN,
  instr_sequencer_if.master sq
);

  // State encodings (visible on SQState)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  // Opcode classes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // True for any of the nine recognised opcodes
  function automatic logic op_is_legal(input logic [6:0] op);
    logic res;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: res = 1'b1;
      default:                           res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic op_is_load(input logic [6:0] op);
    return (op == OP_LOAD);
  endfunction

  function automatic logic op_is_store(input logic [6:0] op);
    return (op == OP_STORE);
  endfunction

  function automatic logic op_is_branch(input logic [6:0] op);
    return (op == OP_BRANCH);
  endfunction

  // Loads and stores are the only classes that visit MEM
  function automatic logic op_is_mem(input logic [6:0] op);
    return op_is_load(op) || op_is_store(op);
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [6:0]  opcode_r;
  logic        illegal_r;
  logic [31:0] retired_r;

  logic        fetch_go_s;
  logic        mem_done_s;
  logic        im_req_s;
  logic        ir_wr_s;
  logic        dm_req_s;
  logic        dm_wr_en_s;
  logic        ru_wr_en_s;
  logic        pc_wr_s;

  // Qualified handshake events: a fetch only completes when not halted, and
  // the data memory ready only matters while in MEM.
  always_comb begin
    fetch_go_s = 1'b0;
    mem_done_s = 1'b0;
    if (state_r == ST_FETCH) begin
      fetch_go_s = !sq.SQHalt && sq.SQIMReady;
    end else begin
      fetch_go_s = 1'b0;
    end
    if (state_r == ST_MEM) begin
      mem_done_s = sq.SQDMReady;
    end else begin
      mem_done_s = 1'b0;
    end
  end

  // Next-state selection
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (fetch_go_s) begin
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (op_is_legal(opcode_r)) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (op_is_mem(opcode_r)) begin
          state_nxt_s = ST_MEM;
        end else if (op_is_branch(opcode_r)) begin
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (!mem_done_s) begin
          state_nxt_s = ST_MEM;
        end else if (op_is_load(opcode_r)) begin
          state_nxt_s = ST_WB;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_WB:   state_nxt_s = ST_FETCH;
      ST_TRAP: state_nxt_s = ST_TRAP;
      // Codes 5 and 6 are never entered normally; recover via FETCH
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Output strobes decoded from state and latched opcode
  always_comb begin
    im_req_s   = 1'b0;
    ir_wr_s    = 1'b0;
    dm_req_s   = 1'b0;
    dm_wr_en_s = 1'b0;
    ru_wr_en_s = 1'b0;
    pc_wr_s    = 1'b0;
    case (state_r)
      ST_FETCH: begin
        im_req_s = !sq.SQHalt;
        ir_wr_s  = fetch_go_s;
      end
      ST_EXEC: begin
        if (op_is_branch(opcode_r)) begin
          pc_wr_s = 1'b1;
        end else begin
          pc_wr_s = 1'b0;
        end
      end
      ST_MEM: begin
        dm_req_s   = 1'b1;
        dm_wr_en_s = op_is_store(opcode_r);
        if (op_is_store(opcode_r)) begin
          pc_wr_s = mem_done_s;
        end else begin
          pc_wr_s = 1'b0;
        end
      end
      ST_WB: begin
        ru_wr_en_s = 1'b1;
        pc_wr_s    = 1'b1;
      end
      default: begin
        im_req_s = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge SQClk or negedge SQRstN) begin
    if (!SQRstN) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Instruction register: capture opcode on the fetch completion cycle
  always_ff @(posedge SQClk or negedge SQRstN) begin
    if (!SQRstN) begin
      opcode_r <= 7'd0;
    end else if (ir_wr_s) begin
      opcode_r <= sq.SQIMOpcode;
    end else begin
      opcode_r <= opcode_r;
    end
  end

  // Sticky illegal flag, set on the DECODE -> TRAP transition
  always_ff @(posedge SQClk or negedge SQRstN) begin
    if (!SQRstN) begin
      illegal_r <= 1'b0;
    end else if ((state_r == ST_DECODE) && !op_is_legal(opcode_r)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Retired-instruction counter, one count per PC update, wraps at 2^32
  always_ff @(posedge SQClk or negedge SQRstN) begin
    if (!SQRstN) begin
      retired_r <= 32'd0;
    end else if (pc_wr_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign sq.SQIMReq   = im_req_s;
  assign sq.SQIRWr    = ir_wr_s;
  assign sq.SQDMReq   = dm_req_s;
  assign sq.SQDMWrEn  = dm_wr_en_s;
  assign sq.SQRUWrEn  = ru_wr_en_s;
  assign sq.SQPCWr    = pc_wr_s;
  assign sq.SQIllegal = illegal_r;
  assign sq.SQState   = state_r;
  assign sq.SQRetired = retired_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: table of instruction vectors expanded into a
// per-cycle expectation queue, plus hand-written halt, wrap, reset-in-MEM
// and trap sequences.
module tb_instr_sequencer;

  logic SQClk;
  logic SQRstN;

  instr_sequencer_if sq_if ();

  instr_sequencer dut (
    .SQClk  (SQClk),
    .SQRstN (SQRstN),
    .sq     (sq_if)
  );

  initial SQClk = 1'b0;
  always #5 SQClk = ~SQClk;

  typedef struct {
    string      name;
    logic [6:0] opcode;
    int         dm_wait;
    bit         mem;
    bit         wb;
    bit         store;
  } vec_t;

  typedef struct {
    logic       in_im;
    logic       in_dm;
    logic [2:0] st;
    logic       irwr;
    logic       pcwr;
    logic       ruwr;
    logic       dmwr;
    logic       dmreq;
  } cyc_t;

  cyc_t        sb[$];
  vec_t        vecs[11];
  int          n_pass;
  int          n_total;
  logic [31:0] exp_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic push(input logic im, input logic dm, input logic [2:0] st,
                      input logic irwr, input logic pcwr, input logic ruwr,
                      input logic dmwr, input logic dmreq);
    cyc_t c;
    c.in_im = im; c.in_dm = dm; c.st = st; c.irwr = irwr;
    c.pcwr = pcwr; c.ruwr = ruwr; c.dmwr = dmwr; c.dmreq = dmreq;
    sb.push_back(c);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, ending in an idle FETCH
  task automatic build_trace(input vec_t v);
    push(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 3'd2, 1'b0, (!v.mem && !v.wb), 1'b0, 1'b0, 1'b0);
    if (v.mem) begin
      for (int w = 0; w <= v.dm_wait; w++) begin
        push(1'b1, (w == v.dm_wait), 3'd3, 1'b0, (w == v.dm_wait) && v.store,
             1'b0, v.store, 1'b1);
      end
    end
    if (v.wb) begin
      push(1'b1, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    push(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drain the scoreboard: drive inputs after the rising edge, compare at the falling edge
  task automatic run_queue(input string tag);
    cyc_t c;
    int   k;
    k = 0;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      sq_if.SQIMReady = c.in_im;
      sq_if.SQDMReady = c.in_dm;
      @(negedge SQClk);
      check($sformatf("%s c%0d state", tag, k), {29'd0, sq_if.SQState}, {29'd0, c.st});
      check($sformatf("%s c%0d irwr", tag, k), {31'd0, sq_if.SQIRWr}, {31'd0, c.irwr});
      check($sformatf("%s c%0d pcwr", tag, k), {31'd0, sq_if.SQPCWr}, {31'd0, c.pcwr});
      check($sformatf("%s c%0d ruwr", tag, k), {31'd0, sq_if.SQRUWrEn}, {31'd0, c.ruwr});
      check($sformatf("%s c%0d dmwr", tag, k), {31'd0, sq_if.SQDMWrEn}, {31'd0, c.dmwr});
      check($sformatf("%s c%0d dmreq", tag, k), {31'd0, sq_if.SQDMReq}, {31'd0, c.dmreq});
      check($sformatf("%s c%0d imreq", tag, k), {31'd0, sq_if.SQIMReq}, {31'd0, (c.st == 3'd0)});
      check($sformatf("%s c%0d illegal", tag, k), {31'd0, sq_if.SQIllegal}, 32'd0);
      if (c.pcwr) exp_retired = exp_retired + 32'd1;
      @(posedge SQClk);
      #1;
      k++;
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    exp_retired = 32'd0;

    vecs[0]  = '{"R",      7'b0110011, 0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{"I",      7'b0010011, 0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{"LOAD0",  7'b0000011, 0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{"LOAD3",  7'b0000011, 3, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{"STORE0", 7'b0100011, 0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{"STORE2", 7'b0100011, 2, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{"BRANCH", 7'b1100011, 0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"JAL",    7'b1101111, 0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{"JALR",   7'b1100111, 0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"LUI",    7'b0110111, 0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"AUIPC",  7'b0010111, 0, 1'b0, 1'b1, 1'b0};

    // Reset state, with and without halt
    SQRstN = 1'b0;
    sq_if.SQHalt = 1'b1;
    sq_if.SQIMReady = 1'b0;
    sq_if.SQDMReady = 1'b0;
    sq_if.SQIMOpcode = 7'd0;
    #2;
    check("rst imreq halted", {31'd0, sq_if.SQIMReq}, 32'd0);
    sq_if.SQHalt = 1'b0;
    #1;
    check("rst imreq", {31'd0, sq_if.SQIMReq}, 32'd1);
    check("rst state", {29'd0, sq_if.SQState}, 32'd0);
    check("rst pcwr", {31'd0, sq_if.SQPCWr}, 32'd0);
    check("rst dmreq", {31'd0, sq_if.SQDMReq}, 32'd0);
    check("rst illegal", {31'd0, sq_if.SQIllegal}, 32'd0);
    check("rst retired", sq_if.SQRetired, 32'd0);
    @(negedge SQClk);
    SQRstN = 1'b1;
    @(posedge SQClk);
    #1;

    // Halt with instruction data valid: nothing is fetched
    sq_if.SQHalt = 1'b1;
    sq_if.SQIMReady = 1'b1;
    sq_if.SQIMOpcode = 7'b0110011;
    for (int i = 0; i < 3; i++) begin
      @(negedge SQClk);
      check($sformatf("halt%0d imreq", i), {31'd0, sq_if.SQIMReq}, 32'd0);
      check($sformatf("halt%0d irwr", i), {31'd0, sq_if.SQIRWr}, 32'd0);
      check($sformatf("halt%0d state", i), {29'd0, sq_if.SQState}, 32'd0);
      @(posedge SQClk);
      #1;
    end
    sq_if.SQHalt = 1'b0;

    // Table-driven instruction vectors
    for (int v = 0; v < 11; v++) begin
      sq_if.SQIMOpcode = vecs[v].opcode;
      build_trace(vecs[v]);
      run_queue(vecs[v].name);
      check($sformatf("%s retired", vecs[v].name), sq_if.SQRetired, exp_retired);
    end

    // Counter wrap: preload all-ones, then retire one branch
    force dut.retired_r = 32'hFFFF_FFFF;
    #1;
    release dut.retired_r;
    @(negedge SQClk);
    check("wrap preload", sq_if.SQRetired, 32'hFFFF_FFFF);
    exp_retired = 32'hFFFF_FFFF;
    @(posedge SQClk);
    #1;
    sq_if.SQIMOpcode = vecs[6].opcode;
    build_trace(vecs[6]);
    run_queue("WRAP");
    check("wrap retired", sq_if.SQRetired, 32'd0);

    // Reset pulsed during a MEM wait
    sq_if.SQIMOpcode = 7'b0000011;
    push(1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_queue("MEMRST");
    #1;
    SQRstN = 1'b0;
    #1;
    check("memrst state", {29'd0, sq_if.SQState}, 32'd0);
    check("memrst dmreq", {31'd0, sq_if.SQDMReq}, 32'd0);
    sq_if.SQDMReady = 1'b1;
    @(negedge SQClk);
    check("memrst pcwr", {31'd0, sq_if.SQPCWr}, 32'd0);
    check("memrst ruwr", {31'd0, sq_if.SQRUWrEn}, 32'd0);
    check("memrst dmwr", {31'd0, sq_if.SQDMWrEn}, 32'd0);
    @(posedge SQClk);
    #1;
    check("memrst retired", sq_if.SQRetired, 32'd0);
    exp_retired = 32'd0;
    #2;
    SQRstN = 1'b1;
    sq_if.SQIMOpcode = vecs[0].opcode;
    build_trace(vecs[0]);
    run_queue("RESTART");
    check("restart retired", sq_if.SQRetired, exp_retired);

    // Illegal opcode: TRAP is absorbing and silent
    sq_if.SQIMOpcode = 7'b1111111;
    push(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    push(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_queue("ILL");
    for (int i = 0; i < 20; i++) begin
      sq_if.SQIMReady = i[0];
      sq_if.SQDMReady = !i[0];
      @(negedge SQClk);
      check($sformatf("trap%0d state", i), {29'd0, sq_if.SQState}, 32'd7);
      check($sformatf("trap%0d illegal", i), {31'd0, sq_if.SQIllegal}, 32'd1);
      check($sformatf("trap%0d strobes", i),
            {26'd0, sq_if.SQIMReq, sq_if.SQIRWr, sq_if.SQDMReq,
             sq_if.SQDMWrEn, sq_if.SQRUWrEn, sq_if.SQPCWr}, 32'd0);
      @(posedge SQClk);
      #1;
    end
    check("trap retired", sq_if.SQRetired, exp_retired);
    SQRstN = 1'b0;
    #1;
    check("trap clr illegal", {31'd0, sq_if.SQIllegal}, 32'd0);
    check("trap clr state", {29'd0, sq_if.SQState}, 32'd0);
    check("trap clr retired", sq_if.SQRetired, 32'd0);
    #2;
    SQRstN = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
